// File: rtl/us_mac_rx_if.sv
// AXI-Stream bundle used on both sides of the MAC receive header stripper.
interface us_mac_rx_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/us_mac_rx.sv
// Ethernet receive stage: strips the 14-byte header, filters on dst MAC and EtherType,
// and realigns the payload by two bytes onto a 64-bit output stream.
module us_mac_rx (
    input  logic        rx_axis_aclk,
    input  logic        rx_axis_areset,
    input  logic [47:0] local_mac_addr,
    us_mac_rx_if.slave  mac_rx_axis,
    us_mac_rx_if.master frame_rx_axis,
    output logic [15:0] rx_eth_type,
    output logic [47:0] rx_src_mac_addr,
    output logic        frame_drop,
    output logic [15:0] rx_drop_cnt
);
    typedef enum logic [2:0] {StHdr0, StHdr1, StPayload, StFlush, StDrop} state_e;

    state_e      state_q;
    logic        dst_match_q;
    logic [15:0] src_hi_q;
    logic [15:0] residue_q;
    logic [3:0]  last_k_q;
    logic [63:0] out_data_q;
    logic [7:0]  out_keep_q;
    logic        out_valid_q;
    logic        out_last_q;

    logic        out_free;
    logic        in_ready;
    logic        in_fire;
    logic [3:0]  keep_cnt;
    logic [47:0] dst_mac;
    logic [31:0] src_lo;
    logic [15:0] eth_type;
    logic        hdr1_accept;

    // Wire byte 0 sits in lane 0 but is the most significant byte of a MAC/EtherType.
    assign dst_mac  = {mac_rx_axis.tdata[7:0],   mac_rx_axis.tdata[15:8],
                       mac_rx_axis.tdata[23:16], mac_rx_axis.tdata[31:24],
                       mac_rx_axis.tdata[39:32], mac_rx_axis.tdata[47:40]};
    assign src_lo   = {mac_rx_axis.tdata[7:0],   mac_rx_axis.tdata[15:8],
                       mac_rx_axis.tdata[23:16], mac_rx_axis.tdata[31:24]};
    assign eth_type = {mac_rx_axis.tdata[39:32], mac_rx_axis.tdata[47:40]};

    assign hdr1_accept = dst_match_q && !mac_rx_axis.tlast &&
                         (eth_type == 16'h0800 || eth_type == 16'h0806);

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            keep_cnt = keep_cnt + {3'b000, mac_rx_axis.tkeep[i]};
        end
    end

    assign out_free = !out_valid_q || frame_rx_axis.tready;

    always_comb begin
        in_ready = 1'b0;
        if (!rx_axis_areset) begin
            case (state_q)
                StHdr0, StHdr1, StDrop: in_ready = 1'b1;
                StPayload:              in_ready = out_free;
                default:                in_ready = 1'b0;
            endcase
        end
    end

    assign in_fire            = in_ready && mac_rx_axis.tvalid;
    assign mac_rx_axis.tready = in_ready;

    assign frame_rx_axis.tdata  = out_data_q;
    assign frame_rx_axis.tkeep  = out_keep_q;
    assign frame_rx_axis.tvalid = out_valid_q;
    assign frame_rx_axis.tlast  = out_last_q;

    always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_areset) begin
            state_q         <= StHdr0;
            dst_match_q     <= 1'b0;
            src_hi_q        <= '0;
            residue_q       <= '0;
            last_k_q        <= '0;
            out_data_q      <= '0;
            out_keep_q      <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            rx_eth_type     <= '0;
            rx_src_mac_addr <= '0;
            frame_drop      <= 1'b0;
            rx_drop_cnt     <= '0;
        end else begin
            frame_drop <= 1'b0;
            if (out_valid_q && frame_rx_axis.tready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StHdr0: begin
                    if (in_fire) begin
                        dst_match_q <= (dst_mac == local_mac_addr) ||
                                       (dst_mac == 48'hFFFF_FFFF_FFFF);
                        src_hi_q    <= {mac_rx_axis.tdata[55:48], mac_rx_axis.tdata[63:56]};
                        if (mac_rx_axis.tlast) begin
                            // Runt: its tlast is already consumed, so the next beat is a new W0.
                            frame_drop  <= 1'b1;
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                        end else begin
                            state_q <= StHdr1;
                        end
                    end
                end
                StHdr1: begin
                    if (in_fire) begin
                        rx_eth_type     <= eth_type;
                        rx_src_mac_addr <= {src_hi_q, src_lo};
                        residue_q       <= mac_rx_axis.tdata[63:48];
                        if (hdr1_accept) begin
                            state_q <= StPayload;
                        end else begin
                            frame_drop  <= 1'b1;
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                            state_q     <= mac_rx_axis.tlast ? StHdr0 : StDrop;
                        end
                    end
                end
                StPayload: begin
                    if (in_fire) begin
                        out_data_q  <= {mac_rx_axis.tdata[47:0], residue_q};
                        residue_q   <= mac_rx_axis.tdata[63:48];
                        out_valid_q <= 1'b1;
                        out_keep_q  <= 8'hFF;
                        out_last_q  <= 1'b0;
                        if (mac_rx_axis.tlast) begin
                            last_k_q <= keep_cnt;
                            if (keep_cnt <= 4'd6) begin
                                out_keep_q <= 8'((9'd1 << (keep_cnt + 4'd2)) - 9'd1);
                                out_last_q <= 1'b1;
                                state_q    <= StHdr0;
                            end else begin
                                state_q <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        out_data_q  <= {48'h0, residue_q};
                        out_keep_q  <= 8'((9'd1 << (last_k_q - 4'd6)) - 9'd1);
                        out_last_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StHdr0;
                    end
                end
                StDrop: begin
                    if (in_fire && mac_rx_axis.tlast) begin
                        state_q <= StHdr0;
                    end
                end
                default: state_q <= StHdr0;
            endcase
        end
    end
endmodule

// File: tb/tb_us_mac_rx.sv
// Bench for us_mac_rx: directed and random frames checked against a byte-level frame model.
module tb_us_mac_rx;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    localparam logic [47:0] LocalMac = 48'h02_11_22_33_44_55;

    logic        clk;
    logic        rst;
    logic [15:0] rx_eth_type;
    logic [47:0] rx_src_mac_addr;
    logic        frame_drop;
    logic [15:0] rx_drop_cnt;

    us_mac_rx_if mac_if ();
    us_mac_rx_if frm_if ();

    us_mac_rx dut (
        .rx_axis_aclk    (clk),
        .rx_axis_areset  (rst),
        .local_mac_addr  (LocalMac),
        .mac_rx_axis     (mac_if),
        .frame_rx_axis   (frm_if),
        .rx_eth_type     (rx_eth_type),
        .rx_src_mac_addr (rx_src_mac_addr),
        .frame_drop      (frame_drop),
        .rx_drop_cnt     (rx_drop_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frm[$];
    word_t       out_q[$];
    word_t       exp_q[$];
    int          exp_drops = 0;
    int          drop_pulses = 0;
    int          ready_low = 0;
    bit          saw_last = 0;
    bit          rand_ready = 0;
    logic [15:0] exp_type = '0;
    logic [47:0] exp_src = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Output sink: always ready, or a coin flip each cycle.
    initial begin
        frm_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            frm_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor, sampled mid-cycle where everything is settled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frm_if.tvalid && frm_if.tready) begin
                    out_q.push_back('{data: frm_if.tdata, keep: frm_if.tkeep, last: frm_if.tlast});
                    if (frm_if.tlast) saw_last = 1'b1;
                end
                if (frame_drop) drop_pulses++;
                if (!mac_if.tready) ready_low++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input int len);
        logic [47:0] src = {16'($urandom), 32'($urandom)};
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47 - 8 * i -: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    // Reference: filter the whole frame, then pack payload bytes 8 per word.
    task automatic model_frame();
        int          n = frm.size();
        logic [47:0] dst;
        logic [15:0] et;
        int          pl;
        int          nw;
        word_t       w;
        if (n <= 8) begin
            exp_drops++;
            return;
        end
        dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        et  = {frm[12], frm[13]};
        exp_type = et;
        exp_src  = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
        if (n > 16 && (dst == LocalMac || dst == 48'hFFFF_FFFF_FFFF) &&
            (et == 16'h0800 || et == 16'h0806)) begin
            pl = n - 14;
            nw = (pl + 7) / 8;
            for (int wi = 0; wi < nw; wi++) begin
                w = '0;
                for (int b = 0; b < 8; b++) begin
                    if (wi * 8 + b < pl) begin
                        w.data[b * 8 +: 8] = frm[14 + wi * 8 + b];
                        w.keep[b]          = 1'b1;
                    end
                end
                w.last = (wi == nw - 1);
                exp_q.push_back(w);
            end
        end else begin
            exp_drops++;
        end
    endtask

    task automatic get_beat(input int b, output logic [63:0] d, output logic [7:0] k,
                            output logic l);
        int nb = (frm.size() + 7) / 8;
        l = (b == nb - 1);
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (b * 8 + i < frm.size()) begin
                d[i * 8 +: 8] = frm[b * 8 + i];
                k[i]          = 1'b1;
            end else begin
                d[i * 8 +: 8] = 8'($urandom);
            end
        end
        if (!l) k = 8'($urandom);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit acc = 1'b0;
        int n = 0;
        mac_if.tdata  = d;
        mac_if.tkeep  = k;
        mac_if.tlast  = l;
        mac_if.tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = mac_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("in_ready_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_frame();
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        model_frame();
        for (int b = 0; b < (frm.size() + 7) / 8; b++) begin
            get_beat(b, d, k, l);
            drive_beat(d, k, l);
        end
    endtask

    task automatic idle();
        mac_if.tvalid = 1'b0;
        mac_if.tlast  = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int want_words, input logic [7:0] want_keep);
        int          n = 0;
        int          m;
        logic [63:0] mask;
        while ((out_q.size() < exp_q.size() || frm_if.tvalid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_words"}, 64'(out_q.size()), 64'(exp_q.size()));
        if (want_words >= 0) begin
            chk({tag, "_nwords"}, 64'(out_q.size()), 64'(want_words));
            if (out_q.size() > 0) chk({tag, "_lastkeep"}, 64'(out_q[out_q.size() - 1].keep), 64'(want_keep));
        end
        m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            for (int b = 0; b < 8; b++) mask[b * 8 +: 8] = {8{exp_q[i].keep[b]}};
            chk({tag, "_data"}, out_q[i].data & mask, exp_q[i].data);
            chk({tag, "_keep"}, 64'(out_q[i].keep), 64'(exp_q[i].keep));
            chk({tag, "_last"}, 64'(out_q[i].last), 64'(exp_q[i].last));
        end
        chk({tag, "_eth_type"}, 64'(rx_eth_type), 64'(exp_type));
        chk({tag, "_src_mac"}, 64'(rx_src_mac_addr), 64'(exp_src));
        chk({tag, "_drop_cnt"}, 64'(rx_drop_cnt), 64'(exp_drops[15:0]));
        chk({tag, "_drop_pulses"}, 64'(drop_pulses), 64'(exp_drops));
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 64'(frm_if.tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(frm_if.tlast), 64'd0);
        chk({tag, "_tdata"}, frm_if.tdata, 64'd0);
        chk({tag, "_tkeep"}, 64'(frm_if.tkeep), 64'd0);
        chk({tag, "_in_tready"}, 64'(mac_if.tready), 64'd0);
        chk({tag, "_drop"}, 64'(frame_drop), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(rx_drop_cnt), 64'd0);
        chk({tag, "_eth_type"}, 64'(rx_eth_type), 64'd0);
        chk({tag, "_src_mac"}, 64'(rx_src_mac_addr), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [47:0] dst;
        logic [15:0] et;
        rst = 1'b1;
        mac_if.tdata  = '0;
        mac_if.tkeep  = '0;
        mac_if.tlast  = 1'b0;
        mac_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Unicast IPv4, 60 bytes.
        ready_low = 0;
        build_frame(LocalMac, 16'h0800, 60);
        send_frame();
        idle();
        check_frames("ipv4_60", 6, 8'h3F);
        chk("ipv4_60_ready_low", 64'(ready_low), 64'd0);
        chk("ipv4_60_type", 64'(rx_eth_type), 64'h0800);

        // Broadcast ARP, 42 bytes.
        build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 42);
        send_frame();
        idle();
        check_frames("arp_42", 4, 8'h0F);
        chk("arp_42_type", 64'(rx_eth_type), 64'h0806);

        // 64 bytes: last beat full, so a flush word follows.
        ready_low = 0;
        build_frame(LocalMac, 16'h0800, 64);
        send_frame();
        idle();
        check_frames("full_64", 7, 8'h03);
        chk("full_64_ready_low", 64'(ready_low), 64'd1);

        // Wrong dst, then IPv6: both dropped, back to back.
        ready_low = 0;
        build_frame(48'h02_11_22_33_44_56, 16'h0800, 60);
        send_frame();
        build_frame(LocalMac, 16'h86DD, 60);
        send_frame();
        idle();
        check_frames("drops", 0, 8'h00);
        chk("drops_cnt2", 64'(rx_drop_cnt), 64'd2);
        chk("drops_ready_low", 64'(ready_low), 64'd0);

        // Runt ending in W0.
        build_frame(LocalMac, 16'h0800, 6);
        send_frame();
        idle();
        check_frames("runt", 0, 8'h00);

        // Back-pressured sink, two frames back to back.
        rand_ready = 1'b1;
        build_frame(LocalMac, 16'h0800, 60);
        send_frame();
        build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 42);
        send_frame();
        idle();
        check_frames("bp_pair", 10, 8'h0F);
        rand_ready = 1'b0;

        // Reset while beat 4 of 8 is presented.
        saw_last = 1'b0;
        build_frame(LocalMac, 16'h0800, 60);
        for (int b = 0; b < 4; b++) begin
            get_beat(b, d, k, l);
            drive_beat(d, k, l);
        end
        get_beat(4, d, k, l);
        mac_if.tdata = d;
        mac_if.tkeep = k;
        mac_if.tlast = l;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        chk("midreset_no_tlast", 64'(saw_last), 64'd0);
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
        out_q.delete();
        exp_q.delete();
        exp_drops   = 0;
        drop_pulses = 0;
        exp_type    = '0;
        exp_src     = '0;
        build_frame(LocalMac, 16'h0800, 60);
        send_frame();
        idle();
        check_frames("post_reset", 6, 8'h3F);

        // Random frames with random filtering outcome and back-pressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0:       dst = LocalMac;
                1:       dst = 48'hFFFF_FFFF_FFFF;
                default: dst = {16'($urandom), 32'($urandom)};
            endcase
            case ($urandom_range(0, 3))
                0:       et = 16'h0800;
                1:       et = 16'h0806;
                2:       et = 16'h86DD;
                default: et = 16'($urandom);
            endcase
            build_frame(dst, et, $urandom_range(14, 100));
            send_frame();
            if ($urandom_range(0, 1) == 0) idle();
            if (it % 4 == 3) begin
                idle();
                check_frames("random", -1, 8'h00);
            end
        end
        idle();
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
